// File: rtl/wb_mon_pkg.sv
// -----------------------------------------------------------------------------
// wb_mon_pkg
// Shared definitions for the Wishbone protocol monitor: the rule enumeration
// (which is also the bit position of each rule inside a port's flag group)
// and the per-port checker state enumeration.
// -----------------------------------------------------------------------------
package wb_mon_pkg;

   localparam int NUM_RULES = 5;

   typedef enum logic [2:0] {
      RULE_ACK_NO_REQ    = 3'd0,
      RULE_STB_NO_CYC    = 3'd1,
      RULE_ATTR_UNSTABLE = 3'd2,
      RULE_RESET_EXIT    = 3'd3,
      RULE_ACK_TIMEOUT   = 3'd4
   } rule_e;

   typedef enum logic [1:0] {
      ST_INIT = 2'd0,
      ST_IDLE = 2'd1,
      ST_WAIT = 2'd2,
      ST_TOUT = 2'd3
   } state_e;

endpackage

// File: rtl/wb_mon_port.sv
// -----------------------------------------------------------------------------
// wb_mon_port
// Protocol checker for one observed Wishbone slave port. Produces a one-cycle
// event pulse per rule for the current sample edge; the top turns these into
// sticky flags, counts and first-error capture.
//
// Optional feature: define WB_MON_TIMEOUT_EN to build the wait counter, the
// TOUT state and the ACK_TIMEOUT rule. Without it a request waits forever.
//
// Ports
//   clk, rst   : clock, asynchronous active-high reset
//   cyc, stb,
//   we, ack    : observed bus handshake / direction bits
//   sel, adr   : observed byte selects and address
//   evt        : violation events seen at this edge, indexed by rule_e
// -----------------------------------------------------------------------------
module wb_mon_port
   import wb_mon_pkg::*;
#(
   parameter int AW          = 32,
   parameter int SEL_W       = 4,
   parameter int TIMEOUT_CYC = 256
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 cyc,
   input  logic                 stb,
   input  logic                 we,
   input  logic                 ack,
   input  logic [SEL_W-1:0]     sel,
   input  logic [AW-1:0]        adr,
   output logic [NUM_RULES-1:0] evt
);

   state_e state_q, state_d;
   logic   req;
   logic   attr_chg;
   logic   wait_done;

   logic [AW-1:0]    adr_q;
   logic [SEL_W-1:0] sel_q;
   logic             we_q;

   assign req = stb & cyc;

   // NOTE: previous-cycle attribute copies carry no reset; they are only
   // compared in WAIT, which is always preceded by at least one capture edge.
   always_ff @(posedge clk) begin
      adr_q <= adr;
      sel_q <= sel;
      we_q  <= we;
   end

   assign attr_chg = (adr != adr_q) || (sel != sel_q) || (we != we_q);

`ifdef WB_MON_TIMEOUT_EN
   localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
   logic [CW-1:0] wait_cnt;

   assign wait_done = (wait_cnt == CW'(TIMEOUT_CYC - 1));

   // Cleared on every WAIT entry, counts only while staying in WAIT.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wait_cnt <= '0;
      end else if (state_q != ST_WAIT && state_d == ST_WAIT) begin
         wait_cnt <= '0;
      end else if (state_q == ST_WAIT && state_d == ST_WAIT) begin
         wait_cnt <= wait_cnt + 1'b1;
      end
   end
`else
   assign wait_done = 1'b0;
`endif

   // NOTE: state flops use non-blocking assignment so every flop in the
   // design samples the pre-edge values regardless of process ordering.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ST_INIT;
      else     state_q <= state_d;
   end

   // NOTE: every output of this block gets a default first, so no path
   // through the case can leave a value unassigned and infer a latch.
   always_comb begin
      state_d = state_q;
      evt     = '0;
      evt[RULE_ACK_NO_REQ] = ack & ~req;
      evt[RULE_STB_NO_CYC] = stb & ~cyc;
      case (state_q)
         ST_INIT: begin
            // First edge after reset release: the master must be quiet.
            state_d = ST_IDLE;
            evt[RULE_RESET_EXIT] = stb | cyc;
         end
         ST_IDLE: begin
            if (req && !ack) state_d = ST_WAIT;
         end
         ST_WAIT: begin
            evt[RULE_ATTR_UNSTABLE] = attr_chg;
            if (ack || !req) begin
               state_d = ST_IDLE;
            end else if (wait_done) begin
               state_d = ST_TOUT;
               evt[RULE_ACK_TIMEOUT] = 1'b1;
            end
         end
         ST_TOUT: begin
            if (ack || !req) state_d = ST_IDLE;
         end
         default: state_d = ST_INIT;
      endcase
   end

endmodule

// File: rtl/wb_protocol_monitor.sv
// -----------------------------------------------------------------------------
// wb_protocol_monitor
// Passive Wishbone protocol monitor for NUM_PORTS slave ports. One wb_mon_port
// checker per port; this level keeps sticky flags, a saturating violation
// count, the interrupt and the first-violation record.
//
// Optional feature: define WB_MON_TIMEOUT_EN to enable ack-timeout checking
// (rule 4). Without it the rule-4 flags remain 0.
// Requires NUM_PORTS >= 2 (first_err_o carries a non-empty port field).
//
// Ports
//   sys_clk, RESET : clock, asynchronous active-high reset
//   wb_cyc_i, wb_stb_i, wb_we_i, wb_ack_o : observed bits, one per port
//   wb_sel_i, wb_adr_i : observed selects / addresses, port p at slice p
//   clr_i       : synchronous clear of flags, count and first error
//   err_flags_o : sticky flags, bit port*5+rule
//   err_cnt_o   : saturating count of violation events
//   err_irq_o   : OR of the sticky flags
//   first_err_o : {valid, port, rule} of the first violation since clear
// -----------------------------------------------------------------------------
module wb_protocol_monitor
   import wb_mon_pkg::*;
#(
   parameter int NUM_PORTS   = 2,
   parameter int AW          = 32,
   parameter int SEL_W       = 4,
   parameter int TIMEOUT_CYC = 256,
   parameter int CNT_W       = 16
) (
   input  logic                           sys_clk,
   input  logic                           RESET,
   input  logic [NUM_PORTS-1:0]           wb_cyc_i,
   input  logic [NUM_PORTS-1:0]           wb_stb_i,
   input  logic [NUM_PORTS-1:0]           wb_we_i,
   input  logic [NUM_PORTS-1:0]           wb_ack_o,
   input  logic [NUM_PORTS*SEL_W-1:0]     wb_sel_i,
   input  logic [NUM_PORTS*AW-1:0]        wb_adr_i,
   input  logic                           clr_i,
   output logic [NUM_PORTS*NUM_RULES-1:0] err_flags_o,
   output logic [CNT_W-1:0]               err_cnt_o,
   output logic                           err_irq_o,
   output logic [$clog2(NUM_PORTS)+3:0]   first_err_o
);

   localparam int NE   = NUM_PORTS * NUM_RULES;
   localparam int PW   = $clog2(NUM_PORTS);
   localparam int FE_W = PW + 4;
   localparam int EW   = $clog2(NE + 1);
   localparam int SUMW = ((CNT_W > EW) ? CNT_W : EW) + 1;

   logic [NE-1:0]    evt;
   logic [NE-1:0]    flags_d;
   logic [CNT_W-1:0] cnt_base, cnt_d;
   logic [EW-1:0]    pop;
   logic [SUMW-1:0]  sum;
   logic [FE_W-1:0]  first_new, first_d;
   int               low_idx;

   for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
      wb_mon_port #(
         .AW          (AW),
         .SEL_W       (SEL_W),
         .TIMEOUT_CYC (TIMEOUT_CYC)
      ) u_port (
         .clk (sys_clk),
         .rst (RESET),
         .cyc (wb_cyc_i[p]),
         .stb (wb_stb_i[p]),
         .we  (wb_we_i[p]),
         .ack (wb_ack_o[p]),
         .sel (wb_sel_i[p*SEL_W +: SEL_W]),
         .adr (wb_adr_i[p*AW +: AW]),
         .evt (evt[p*NUM_RULES +: NUM_RULES])
      );
   end

   always_comb begin
      pop     = '0;
      low_idx = 0;
      for (int i = 0; i < NE; i++) pop = pop + EW'(evt[i]);
      // Walk downwards so the lowest set bit wins: flat index port*5+rule
      // orders by port first, then rule.
      for (int i = NE - 1; i >= 0; i--) begin
         if (evt[i]) low_idx = i;
      end
      first_new = {1'b1, PW'(low_idx / NUM_RULES), 3'(low_idx % NUM_RULES)};

      // A clear drops old state, but events of the same cycle still land.
      flags_d  = (clr_i ? '0 : err_flags_o) | evt;
      cnt_base = clr_i ? '0 : err_cnt_o;
      sum      = SUMW'(cnt_base) + SUMW'(pop);
      cnt_d    = (sum > SUMW'({CNT_W{1'b1}})) ? {CNT_W{1'b1}} : sum[CNT_W-1:0];

      first_d = first_err_o;
      if (|evt && (clr_i || !first_err_o[FE_W-1])) first_d = first_new;
      else if (clr_i)                              first_d = '0;
   end

   always_ff @(posedge sys_clk or posedge RESET) begin
      if (RESET) begin
         err_flags_o <= '0;
         err_cnt_o   <= '0;
         err_irq_o   <= 1'b0;
         first_err_o <= '0;
      end else begin
         err_flags_o <= flags_d;
         err_cnt_o   <= cnt_d;
         err_irq_o   <= |flags_d;
         first_err_o <= first_d;
      end
   end

endmodule

// File: tb/tb_wb_protocol_monitor.sv
// -----------------------------------------------------------------------------
// tb_wb_protocol_monitor
// Two monitor instances share one stimulus: u_main (8-bit counter) and u_sat
// (2-bit counter). Directed scenarios are followed by random bus traffic;
// all outputs are compared every cycle against a transaction-level model.
// -----------------------------------------------------------------------------
module tb_wb_protocol_monitor;
   import wb_mon_pkg::*;

   localparam int NP = 2;
   localparam int AW = 32;
   localparam int SW = 4;
   localparam int TO = 8;
   localparam int NR = 5;
   localparam int NE = NP * NR;
`ifdef WB_MON_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic             sys_clk = 1'b0;
   logic             RESET   = 1'b0;
   logic [NP-1:0]    cyc = '0, stb = '0, we = '0, ack = '0;
   logic [NP*SW-1:0] sel = '0;
   logic [NP*AW-1:0] adr = '0;
   logic             clr = 1'b0;

   logic [NE-1:0] flags_m, flags_s;
   logic [7:0]    cnt_m;
   logic [1:0]    cnt_s;
   logic          irq_m, irq_s;
   logic [4:0]    first_m, first_s;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: per-port request bookkeeping plus error accounting.
   bit             m_init  [NP];
   bit             m_out   [NP];   // a request accepted and not yet finished
   bit             m_tout  [NP];   // that request has already timed out
   int             m_age   [NP];   // edges the request has been pending
   logic [AW-1:0]  m_padr  [NP];
   logic [SW-1:0]  m_psel  [NP];
   logic           m_pwe   [NP];
   logic [NE-1:0]  m_flags;
   int             m_cnt_m, m_cnt_s;
   logic [4:0]     m_first;

   always #5 sys_clk = ~sys_clk;

   wb_protocol_monitor #(.NUM_PORTS(NP), .AW(AW), .SEL_W(SW), .TIMEOUT_CYC(TO), .CNT_W(8)) u_main (
      .sys_clk(sys_clk), .RESET(RESET), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
      .wb_ack_o(ack), .wb_sel_i(sel), .wb_adr_i(adr), .clr_i(clr),
      .err_flags_o(flags_m), .err_cnt_o(cnt_m), .err_irq_o(irq_m), .first_err_o(first_m));

   wb_protocol_monitor #(.NUM_PORTS(NP), .AW(AW), .SEL_W(SW), .TIMEOUT_CYC(TO), .CNT_W(2)) u_sat (
      .sys_clk(sys_clk), .RESET(RESET), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
      .wb_ack_o(ack), .wb_sel_i(sel), .wb_adr_i(adr), .clr_i(clr),
      .err_flags_o(flags_s), .err_cnt_o(cnt_s), .err_irq_o(irq_s), .first_err_o(first_s));

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [1:0] exp_state(input int p);
      if (m_init[p])      return 2'(ST_INIT);
      else if (!m_out[p]) return 2'(ST_IDLE);
      else if (m_tout[p]) return 2'(ST_TOUT);
      else                return 2'(ST_WAIT);
   endfunction

   task automatic model_reset();
      for (int p = 0; p < NP; p++) begin
         m_init[p] = 1'b1; m_out[p] = 1'b0; m_tout[p] = 1'b0; m_age[p] = 0;
      end
      m_flags = '0; m_cnt_m = 0; m_cnt_s = 0; m_first = '0;
   endtask

   // Applies the protocol rules to the inputs present at this sample edge.
   task automatic model_edge();
      logic [NE-1:0] ev;
      logic          req, chg;
      int            pop, low;
      ev = '0;
      for (int p = 0; p < NP; p++) begin
         req = stb[p] & cyc[p];
         chg = (adr[p*AW +: AW] != m_padr[p]) || (sel[p*SW +: SW] != m_psel[p]) || (we[p] != m_pwe[p]);
         ev[p*NR + 0] = ack[p] & ~req;
         ev[p*NR + 1] = stb[p] & ~cyc[p];
         if (m_init[p]) begin
            ev[p*NR + 3] = stb[p] | cyc[p];
            m_init[p] = 1'b0;
         end else if (m_out[p]) begin
            if (!m_tout[p]) ev[p*NR + 2] = chg;
            if (ack[p] || !req) begin
               m_out[p] = 1'b0; m_tout[p] = 1'b0;
            end else if (!m_tout[p]) begin
               m_age[p]++;
               if (TO_EN && m_age[p] == TO) begin
                  m_tout[p] = 1'b1;
                  ev[p*NR + 4] = 1'b1;
               end
            end
         end else if (req && !ack[p]) begin
            m_out[p] = 1'b1; m_age[p] = 0;
         end
         m_padr[p] = adr[p*AW +: AW]; m_psel[p] = sel[p*SW +: SW]; m_pwe[p] = we[p];
      end
      pop = $countones(ev);
      if (clr) begin
         m_flags = '0; m_cnt_m = 0; m_cnt_s = 0;
      end
      m_flags |= ev;
      m_cnt_m = (m_cnt_m + pop > 255) ? 255 : m_cnt_m + pop;
      m_cnt_s = (m_cnt_s + pop > 3) ? 3 : m_cnt_s + pop;
      if (ev != '0 && (clr || !m_first[4])) begin
         low = 0;
         for (int i = NE - 1; i >= 0; i--) if (ev[i]) low = i;
         m_first = {1'b1, 1'(low / NR), 3'(low % NR)};
      end else if (clr) begin
         m_first = '0;
      end
   endtask

   task automatic compare_all();
      check("flags",     flags_m, m_flags);
      check("cnt",       cnt_m,   m_cnt_m);
      check("first",     first_m, m_first);
      check("irq",       irq_m,   |m_flags);
      check("flags_sat", flags_s, m_flags);
      check("cnt_sat",   cnt_s,   m_cnt_s);
      check("first_sat", first_s, m_first);
      check("irq_sat",   irq_s,   |m_flags);
      check("state0",    u_main.g_port[0].u_port.state_q, exp_state(0));
      check("state1",    u_main.g_port[1].u_port.state_q, exp_state(1));
   endtask

   // One clock: model follows the sample edge, outputs checked 1ns later.
   task automatic step();
      @(posedge sys_clk);
      model_edge();
      #1;
      compare_all();
   endtask

   // Asserts reset away from any clock edge and checks the asynchronous clear.
   task automatic apply_reset();
      RESET = 1'b1;
      model_reset();
      #1;
      check("rst_flags", flags_m, 0);
      check("rst_cnt",   cnt_m,   0);
      check("rst_irq",   irq_m,   0);
      check("rst_first", first_m, 0);
      check("rst_state", u_main.g_port[0].u_port.state_q, 2'(ST_INIT));
      repeat (2) @(posedge sys_clk);
      @(negedge sys_clk);
      RESET = 1'b0;
   endtask

   task automatic bus_idle();
      cyc = '0; stb = '0; ack = '0;
   endtask

   task automatic clear_all();
      bus_idle();
      clr = 1'b1;
      step();
      clr = 1'b0;
   endtask

   initial begin
      #2;
      apply_reset();
      step();                                   // INIT edge, quiet bus

      // Ack without a request on port 0.
      ack[0] = 1'b1;
      step();
      check("ack_noreq_flag",  flags_m[0], 1);
      check("ack_noreq_cnt",   cnt_m, 1);
      check("ack_noreq_first", first_m, 5'b1_0_000);
      check("ack_noreq_irq",   irq_m, 1);
      clear_all();
      check("clr_cnt", cnt_m, 0);

      // Two violations in one cycle on different ports.
      stb[1] = 1'b1; ack[0] = 1'b1;
      step();
      check("dual_cnt",   cnt_m, 2);
      check("dual_first", first_m, 5'b1_0_000);
      check("dual_flags", flags_m, 10'b00010_00001);
      clear_all();

      // Address changes while waiting for ack.
      cyc[0] = 1'b1; stb[0] = 1'b1; adr[31:0] = 32'h100;
      step();
      step();
      check("attr_stable_flags", flags_m, 0);
      adr[31:0] = 32'h104;
      step();
      check("attr_flag",  flags_m[2], 1);
      check("attr_state", u_main.g_port[0].u_port.state_q, 2'(ST_WAIT));
      ack[0] = 1'b1;
      step();
      check("attr_ack_state", u_main.g_port[0].u_port.state_q, 2'(ST_IDLE));
      clear_all();

      // Request held without ack.
      cyc[0] = 1'b1; stb[0] = 1'b1;
      step();
      repeat (TO - 1) step();
      check("tout_early", flags_m[4], 0);
      step();
      check("tout_flag",  flags_m[4], TO_EN);
      check("tout_state", u_main.g_port[0].u_port.state_q, TO_EN ? 2'(ST_TOUT) : 2'(ST_WAIT));
      repeat (3) step();
      check("tout_once",  cnt_m, TO_EN ? 1 : 0);
      ack[0] = 1'b1;
      step();
      check("tout_ack_state", u_main.g_port[0].u_port.state_q, 2'(ST_IDLE));
      clear_all();

      // Counter saturation, then clear racing a new violation.
      ack[0] = 1'b1;
      repeat (5) step();
      check("sat_cnt",  cnt_s, 3);
      check("main_cnt", cnt_m, 5);
      ack[0] = 1'b0; stb[1] = 1'b1; clr = 1'b1;
      step();
      clr = 1'b0;
      check("clr_race_cnt",   cnt_m, 1);
      check("clr_race_sat",   cnt_s, 1);
      check("clr_race_flags", flags_m, 10'b00010_00000);
      check("clr_race_first", first_m, 5'b1_1_001);
      clear_all();

      // Cycle still high when reset releases, then reset in the middle of WAIT.
      cyc[1] = 1'b1;
      apply_reset();
      step();
      check("rst_exit_flag", flags_m[8], 1);
      cyc[1] = 1'b0; cyc[0] = 1'b1; stb[0] = 1'b1;
      step();
      step();
      check("pre_rst_wait", u_main.g_port[0].u_port.state_q, 2'(ST_WAIT));
      apply_reset();
      bus_idle();
      step();

      // Random traffic, mostly legal with occasional protocol errors.
      for (int n = 0; n < 3000; n++) begin
         for (int p = 0; p < NP; p++) begin
            cyc[p] = ($urandom_range(3) != 0);
            stb[p] = cyc[p] ? ($urandom_range(2) != 0) : ($urandom_range(7) == 0);
            ack[p] = (cyc[p] && stb[p]) ? ($urandom_range(3) == 0) : ($urandom_range(15) == 0);
            if ($urandom_range(11) == 0) adr[p*AW +: AW] = $urandom;
            if ($urandom_range(15) == 0) sel[p*SW +: SW] = SW'($urandom);
            if ($urandom_range(15) == 0) we[p] = ~we[p];
         end
         clr = ($urandom_range(31) == 0);
         if ($urandom_range(499) == 0) apply_reset();
         step();
      end
      clr = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
